// File: rtl/uart_rx_frame_parser.sv
// Pops bytes from the UART receive FIFO, hunts the two-byte header, then parses length/payload/tail.
// Define UART_FRAME_CHECKSUM_EN to carry and verify a checksum byte between payload and tail.
module uart_rx_frame_parser #(
  parameter logic [7:0]  HEAD_BYTE0     = 8'hEB,
  parameter logic [7:0]  HEAD_BYTE1     = 8'h90,
  parameter logic [7:0]  TAIL_BYTE      = 8'h0D,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic       sys_clk_i,
  input  logic       rst_n_i,
  output logic       fifo_rx_rden_o,
  input  logic [7:0] fifo_rx_data_i,
  input  logic       fifo_rx_empty_i,
  input  logic       payload_ready_i,
  output logic       payload_valid_o,
  output logic [7:0] payload_data_o,
  output logic       payload_sop_o,
  output logic       payload_eop_o,
  output logic [7:0] frame_len_o,
  output logic       frame_done_o,
  output logic [2:0] frame_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] ErrOk      = 3'd0;
  localparam logic [2:0] ErrLen     = 3'd1;
  localparam logic [2:0] ErrTail    = 3'd3;
  localparam logic [2:0] ErrTimeout = 3'd4;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] ErrCsum    = 3'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEAD1   = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_TAIL    = 3'd4
`ifdef UART_FRAME_CHECKSUM_EN
    , S_CSUM  = 3'd5
`endif
  } state_e;

  state_e          state_q, state_d;
  logic            strobe_q, strobe_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      rem_q, rem_d;
  logic            pv_q, pv_d;
  logic [7:0]      pdata_q, pdata_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic [7:0]      len_q, len_d;
  logic            done_q, done_d;
  logic [2:0]      err_q, err_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
  logic            csum_ok_q, csum_ok_d;
`endif
  logic            stall;
  logic            expire;
  logic            rden;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    pv_d     = 1'b0;
    pdata_d  = pdata_q;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    len_d    = len_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_d    = csum_q;
    csum_ok_d = csum_ok_q;
`endif
    // Backpressure freezes both reading and the inter-byte timer.
    stall  = (state_q == S_PAYLOAD) && !payload_ready_i;
    expire = (state_q != S_IDLE) && !strobe_q && !stall &&
             (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    rden     = !fifo_rx_empty_i && !strobe_q && !stall && !expire;
    strobe_d = rden;

    if (state_q == S_IDLE || strobe_q) cnt_d = '0;
    else if (!stall)                   cnt_d = cnt_q + CntW'(1);

    if (strobe_q) begin
      unique case (state_q)
        S_IDLE: if (fifo_rx_data_i == HEAD_BYTE0) state_d = S_HEAD1;
        S_HEAD1: begin
          if (fifo_rx_data_i == HEAD_BYTE1)      state_d = S_LEN;
          else if (fifo_rx_data_i != HEAD_BYTE0) state_d = S_IDLE;
        end
        S_LEN: begin
          if (fifo_rx_data_i != 8'd0 && fifo_rx_data_i <= 8'(MAX_LEN)) begin
            len_d   = fifo_rx_data_i;
            rem_d   = fifo_rx_data_i;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_d  = fifo_rx_data_i;
`endif
            state_d = S_PAYLOAD;
          end else begin
            done_d  = 1'b1;
            err_d   = ErrLen;
            state_d = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          pv_d    = 1'b1;
          pdata_d = fifo_rx_data_i;
          sop_d   = (rem_q == len_q);
          eop_d   = (rem_q == 8'd1);
          rem_d   = rem_q - 8'd1;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d  = csum_q + fifo_rx_data_i;
`endif
          if (rem_q == 8'd1) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_TAIL;
`endif
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        S_CSUM: begin
          csum_ok_d = (fifo_rx_data_i == csum_q);
          state_d   = S_TAIL;
        end
`endif
        S_TAIL: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (fifo_rx_data_i != TAIL_BYTE) err_d = ErrTail;
`ifdef UART_FRAME_CHECKSUM_EN
          else if (!csum_ok_q)             err_d = ErrCsum;
`endif
          else                             err_d = ErrOk;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire) begin
      done_d  = 1'b1;
      err_d   = ErrTimeout;
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      strobe_q  <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      pv_q      <= 1'b0;
      pdata_q   <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      len_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q    <= '0;
      csum_ok_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      pv_q      <= pv_d;
      pdata_q   <= pdata_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      len_q     <= len_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q    <= csum_d;
      csum_ok_q <= csum_ok_d;
`endif
    end
  end

  assign fifo_rx_rden_o  = rden;
  assign payload_valid_o = pv_q;
  assign payload_data_o  = pdata_q;
  assign payload_sop_o   = sop_q;
  assign payload_eop_o   = eop_q;
  assign frame_len_o     = len_q;
  assign frame_done_o    = done_q;
  assign frame_err_o     = err_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: FIFO model, payload/status scoreboard, table of frames plus corner sequences.
module tb_uart_rx_frame_parser;

  localparam int unsigned TO   = 20;
  localparam int unsigned MAXL = 64;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rden;
  logic [7:0] dout = 8'h00;
  logic       fifo_empty;
  logic       ready = 1'b1;
  logic       pv, sop, eop, done;
  logic [7:0] pdata, flen;
  logic [2:0] ferr;

  always #5 clk = ~clk;

  uart_rx_frame_parser #(
    .HEAD_BYTE0(8'hEB), .HEAD_BYTE1(8'h90), .TAIL_BYTE(8'h0D),
    .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n),
    .fifo_rx_rden_o(rden), .fifo_rx_data_i(dout), .fifo_rx_empty_i(fifo_empty),
    .payload_ready_i(ready), .payload_valid_o(pv), .payload_data_o(pdata),
    .payload_sop_o(sop), .payload_eop_o(eop), .frame_len_o(flen),
    .frame_done_o(done), .frame_err_o(ferr)
  );

  typedef struct { logic [7:0] data; logic sop; logic eop; } pay_t;
  typedef struct { logic [2:0] err; logic [7:0] len; bit chk_len; } done_t;
  typedef struct {
    logic [7:0] len;
    logic [7:0] pay [8];
    logic [7:0] cx;
    logic [7:0] tail;
    logic [2:0] err;
  } vec_t;

  pay_t       exp_pay [$];
  done_t      exp_done [$];
  logic [7:0] fifo_q [$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] staged = 8'h00;
  bit         staged_v = 1'b0;
  bit         hold_empty = 1'b0;
  bit         bp_arm = 1'b0;
  bit         bp_window = 1'b0;
  int         rden_empty_viol = 0;
  int         bp_viol = 0;
  int         held_rden = 0;
  int         cyc = 0;
  int         last_pv_cyc = 0;
  pay_t       p;
  done_t      d;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // FIFO empty flag follows the queue at the clock edge; the FIFO shares the system reset.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) fifo_empty <= 1'b1;
    else        fifo_empty <= hold_empty || (fifo_q.size() == 0);

  // FIFO read port and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      staged_v  = 1'b0;
      bp_window = 1'b0;
    end else begin
      if (rden && fifo_empty) rden_empty_viol++;
      if (hold_empty && rden) held_rden++;
      if (pv && eop) bp_window = 1'b0;
      if (bp_window && rden && !ready) bp_viol++;
      if (staged_v) begin
        dout     = staged;
        staged_v = 1'b0;
      end
      if (rden && fifo_q.size() > 0) begin
        staged   = fifo_q.pop_front();
        staged_v = 1'b1;
      end
      if (pv) begin
        last_pv_cyc = cyc;
        if (exp_pay.size() == 0) check("unexpected_payload", int'(pdata), -1);
        else begin
          p = exp_pay.pop_front();
          check("payload_data", int'(pdata), int'(p.data));
          check("payload_sop", int'(sop), int'(p.sop));
          check("payload_eop", int'(eop), int'(p.eop));
        end
        if (sop && bp_arm) bp_window = 1'b1;
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", int'(ferr), -1);
        else begin
          d = exp_done.pop_front();
          check("frame_err", int'(ferr), int'(d.err));
          if (d.chk_len) check("frame_len", int'(flen), int'(d.len));
          if (d.err == 3'd4) check("timeout_latency", cyc - last_pv_cyc, int'(TO));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_frame(input logic [7:0] len, input logic [7:0] pay [64],
                            input logic [7:0] cx, input logic [7:0] tail, input logic [2:0] err);
    logic [7:0] sum;
    sum = len;
    fifo_q.push_back(8'hEB);
    fifo_q.push_back(8'h90);
    fifo_q.push_back(len);
    if (len == 8'd0 || int'(len) > int'(MAXL)) begin
      exp_done.push_back('{err, 8'd0, 1'b0});
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      fifo_q.push_back(pay[i]);
      sum = sum + pay[i];
      exp_pay.push_back('{pay[i], i == 0, i == int'(len) - 1});
    end
    if (CSUM_EN) fifo_q.push_back(sum ^ cx);
    fifo_q.push_back(tail);
    exp_done.push_back('{err, len, 1'b1});
  endtask

  task automatic wait_done(input string name, input int budget, input bit toggle);
    int k;
    k = 0;
    while ((exp_done.size() != 0 || exp_pay.size() != 0) && k < budget) begin
      if (toggle) ready = ((k / 3) % 2) == 0;
      step(1);
      k++;
    end
    ready = 1'b1;
    if (k >= budget) check({name, "_completion_budget"}, exp_done.size(), 0);
    step(3);
  endtask

  vec_t       vecs [7];
  logic [7:0] p64 [64];

  initial begin
    vecs[0] = '{len:8'd3, pay:'{8'h11,8'h22,8'h33,8'h00,8'h00,8'h00,8'h00,8'h00}, cx:8'h00, tail:8'h0D, err:3'd0};
    vecs[1] = '{len:8'd0, pay:'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, cx:8'h00, tail:8'h0D, err:3'd1};
    vecs[2] = '{len:8'd65, pay:'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, cx:8'h00, tail:8'h0D, err:3'd1};
    vecs[3] = '{len:8'd2, pay:'{8'h01,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, cx:8'h05, tail:8'h0D,
                err:(CSUM_EN ? 3'd2 : 3'd0)};
    vecs[4] = '{len:8'd2, pay:'{8'h01,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, cx:8'h05, tail:8'h0E, err:3'd3};
    vecs[5] = '{len:8'd1, pay:'{8'hEB,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, cx:8'h00, tail:8'h0D, err:3'd0};
    vecs[6] = '{len:8'd8, pay:'{8'h90,8'h0D,8'hEB,8'hFF,8'h00,8'h7F,8'h80,8'h5A}, cx:8'h00, tail:8'h0D, err:3'd0};

    // Reset state
    step(2);
    check("rst_rden", int'(rden), 0);
    check("rst_valid", int'(pv), 0);
    check("rst_sop", int'(sop), 0);
    check("rst_eop", int'(eop), 0);
    check("rst_len", int'(flen), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(ferr), 0);
    rst_n = 1'b1;
    step(2);

    // Table of frames with ready held high
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 64; i++) p64[i] = (i < 8) ? vecs[k].pay[i] : 8'h00;
      push_frame(vecs[k].len, p64, vecs[k].cx, vecs[k].tail, vecs[k].err);
      wait_done("table", 300, 1'b0);
    end

    // Resync through junk and a doubled first header byte
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hEB);
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'hEB);
    for (int i = 0; i < 64; i++) p64[i] = 8'h00;
    p64[0] = 8'hA5;
    push_frame(8'd1, p64, 8'h00, 8'h0D, 3'd0);
    wait_done("resync", 300, 1'b0);

    // Max-length frame with ready toggling every 3 cycles
    for (int i = 0; i < 64; i++) p64[i] = 8'(i * 7 + 3);
    bp_arm = 1'b1;
    push_frame(8'(MAXL), p64, 8'h00, 8'h0D, 3'd0);
    wait_done("backpressure", 2000, 1'b1);
    bp_arm = 1'b0;
    check("rden_while_not_ready", bp_viol, 0);

    // Empty held high while bytes sit in the queue: no reads
    hold_empty = 1'b1;
    for (int i = 0; i < 64; i++) p64[i] = 8'h00;
    p64[0] = 8'h3C;
    p64[1] = 8'hC3;
    push_frame(8'd2, p64, 8'h00, 8'h0D, 3'd0);
    step(40);
    check("rden_while_empty_held", held_rden, 0);
    check("no_done_while_empty", exp_done.size(), 1);
    hold_empty = 1'b0;
    wait_done("after_empty", 300, 1'b0);

    // FIFO starves after the first payload byte
    fifo_q.push_back(8'hEB);
    fifo_q.push_back(8'h90);
    fifo_q.push_back(8'h05);
    fifo_q.push_back(8'h01);
    exp_pay.push_back('{8'h01, 1'b1, 1'b0});
    exp_done.push_back('{3'd4, 8'd5, 1'b1});
    wait_done("timeout", 300, 1'b0);

    // Reset mid-payload, then a clean frame
    for (int i = 0; i < 64; i++) p64[i] = 8'(8'h20 + i);
    push_frame(8'd8, p64, 8'h00, 8'h0D, 3'd0);
    for (int k = 0; k < 200 && exp_pay.size() > 6; k++) step(1);
    check("reset_reached_mid_payload", exp_pay.size(), 6);
    rst_n = 1'b0;
    fifo_q.delete();
    exp_pay.delete();
    exp_done.delete();
    #1;
    check("midrst_rden", int'(rden), 0);
    check("midrst_valid", int'(pv), 0);
    check("midrst_data", int'(pdata), 0);
    check("midrst_sop", int'(sop), 0);
    check("midrst_eop", int'(eop), 0);
    check("midrst_len", int'(flen), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(ferr), 0);
    step(3);
    rst_n = 1'b1;
    step(2);
    p64[0] = 8'h42;
    p64[1] = 8'h24;
    push_frame(8'd2, p64, 8'h00, 8'h0D, 3'd0);
    wait_done("post_reset", 300, 1'b0);

    check("rden_while_empty", rden_empty_viol, 0);
    check("leftover_payload", exp_pay.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
